key_mem_responder: RTL and testbench

//  AXI4-style burst responder (slave end) for the key write/read-back path in the cryp IP.

---
 rtl/key_mem_responder_if.sv | 52 +++++
 rtl/key_mem_responder.sv | 115 +++++++++++
 tb/tb_key_mem_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/key_mem_responder_if.sv
// key_mem_responder_if: AXI4-style write/read burst channels between the key master and its responder.
interface key_mem_responder_if #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 512
);
    logic [C_AXI_ID_WIDTH-1:0]     axi_awid;
    logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr;
    logic [7:0]                    axi_awlen;
    logic                          axi_awvalid;
    logic                          axi_awready;
    logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata;
    logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb;
    logic                          axi_wlast;
    logic                          axi_wvalid;
    logic                          axi_wready;
    logic [C_AXI_ID_WIDTH-1:0]     axi_bid;
    logic [1:0]                    axi_bresp;
    logic                          axi_bvalid;
    logic                          axi_bready;
    logic [C_AXI_ID_WIDTH-1:0]     axi_arid;
    logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr;
    logic [7:0]                    axi_arlen;
    logic                          axi_arvalid;
    logic                          axi_arready;
    logic [C_AXI_ID_WIDTH-1:0]     axi_rid;
    logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata;
    logic [1:0]                    axi_rresp;
    logic                          axi_rlast;
    logic                          axi_rvalid;
    logic                          axi_rready;

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awvalid,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_bready,
        output axi_arid, axi_araddr, axi_arlen, axi_arvalid,
        output axi_rready,
        input  axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
        input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
    );

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awvalid,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_bready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arvalid,
        input  axi_rready,
        output axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
        output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
    );
endinterface

// File: rtl/key_mem_responder.sv
// key_mem_responder: single-transaction burst responder backed by a 64-bit key store.
// Define KEY_MEM_RANGE_CHECK_EN to reject bursts running past the top of the store with SLVERR.
module key_mem_responder #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 512,
    parameter int MEM_WORDS        = 4096
) (
    input  logic                aclk,
    input  logic                rst,
    key_mem_responder_if.slave  axi,
    output logic                proto_err
);
    localparam int OW = $clog2(C_AXI_DATA_WIDTH / 8);
    localparam int IW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RFETCH, RDATA} state_e;

    state_e                    state_q, state_d;
    logic [C_AXI_ID_WIDTH-1:0] id_q, id_d, a_id;
    logic [7:0]                len_q, len_d, cnt_q, cnt_d, a_len;
    logic [IW-1:0]             idx_q, idx_d, a_idx;
    logic                      oor_q, oor_d, a_oor;
    logic                      proto_q, proto_d;
    logic                      last_beat, we;
    logic [63:0]               mem [MEM_WORDS];
    logic [63:0]               mem_q;

    // Address capture muxes toward AW whenever awvalid is up, since a write wins ties.
    assign a_idx = axi.axi_awvalid ? axi.axi_awaddr[OW +: IW] : axi.axi_araddr[OW +: IW];
    assign a_len = axi.axi_awvalid ? axi.axi_awlen : axi.axi_arlen;
    assign a_id  = axi.axi_awvalid ? axi.axi_awid : axi.axi_arid;
`ifdef KEY_MEM_RANGE_CHECK_EN
    assign a_oor = (32'(a_idx) + 32'(a_len)) > 32'(MEM_WORDS - 1);
`else
    assign a_oor = 1'b0;
`endif

    assign last_beat       = cnt_q == len_q;
    assign axi.axi_awready = !rst && state_q == IDLE;
    assign axi.axi_arready = axi.axi_awready && !axi.axi_awvalid;
    assign axi.axi_wready  = !rst && state_q == WDATA;
    assign axi.axi_bvalid  = !rst && state_q == WRESP;
    assign axi.axi_bid     = axi.axi_bvalid ? id_q : '0;
    assign axi.axi_bresp   = {axi.axi_bvalid && oor_q, 1'b0};
    assign axi.axi_rvalid  = !rst && state_q == RDATA;
    assign axi.axi_rid     = axi.axi_rvalid ? id_q : '0;
    assign axi.axi_rresp   = {axi.axi_rvalid && oor_q, 1'b0};
    assign axi.axi_rlast   = axi.axi_rvalid && last_beat;
    assign axi.axi_rdata   = (axi.axi_rvalid && !oor_q) ? C_AXI_DATA_WIDTH'(mem_q) : '0;
    assign proto_err       = proto_q;
    assign we              = axi.axi_wready && axi.axi_wvalid && !oor_q;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        oor_d   = oor_q;
        proto_d = proto_q;
        case (state_q)
            IDLE: if (axi.axi_awvalid || axi.axi_arvalid) begin
                id_d    = a_id;
                len_d   = a_len;
                idx_d   = a_idx;
                cnt_d   = 8'd0;
                oor_d   = a_oor;
                state_d = axi.axi_awvalid ? WDATA : RFETCH;
            end
            WDATA: if (axi.axi_wvalid) begin
                proto_d = proto_q || (last_beat != axi.axi_wlast);
                idx_d   = idx_q + IW'(1);
                cnt_d   = cnt_q + 8'd1;
                state_d = last_beat ? WRESP : WDATA;
            end
            WRESP:  state_d = axi.axi_bready ? IDLE : WRESP;
            RFETCH: state_d = RDATA;
            RDATA: if (axi.axi_rready) begin
                idx_d   = idx_q + IW'(1);
                cnt_d   = cnt_q + 8'd1;
                state_d = last_beat ? IDLE : RFETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            oor_q   <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            oor_q   <= oor_d;
            proto_q <= proto_d;
        end
    end

    // Store is deliberately not reset so keys survive a responder reset.
    always_ff @(posedge aclk) begin
        if (we)
            for (int k = 0; k < 8; k++)
                if (axi.axi_wstrb[k]) mem[idx_q][8*k +: 8] <= axi.axi_wdata[8*k +: 8];
        if (state_q == RFETCH) mem_q <= mem[idx_q];
    end
endmodule

// File: tb/tb_key_mem_responder.sv
// tb_key_mem_responder: directed bursts against a reference key-store model with a read scoreboard.
module tb_key_mem_responder;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 512;
    localparam int SB  = DW / 8;
    localparam int MEM = 4096;

    logic aclk, rst, proto_err;
    int   n_vec = 0;
    int   n_err = 0;
    logic [63:0] model [MEM];
    logic [64:0] exp_q [$];

    key_mem_responder_if #(.C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW)) axi ();

    key_mem_responder #(
        .C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .MEM_WORDS(MEM)
    ) dut (
        .aclk(aclk), .rst(rst), .axi(axi.slave), .proto_err(proto_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit range_oor(input int widx, input int len);
`ifdef KEY_MEM_RANGE_CHECK_EN
        return widx + len > MEM - 1;
`else
        return 1'b0;
`endif
    endfunction

    // Tasks start and end in a "slot": after a negedge, before the next posedge.
    task automatic do_write(input logic [3:0] id, input int widx, input int len, input int last_at,
                            input logic [63:0] seed, input logic [7:0] strb, input bit exp_proto);
        int k;
        bit oor;
        logic [63:0] d;
        oor = range_oor(widx, len);
        axi.axi_awid = id;
        axi.axi_awaddr = 32'(widx * SB);
        axi.axi_awlen = 8'(len);
        axi.axi_awvalid = 1'b1;
        #1;
        if (axi.axi_arvalid) check("ar_blocked_by_aw", axi.axi_arready, 0);
        k = 0;
        while (!axi.axi_awready && k < 50) begin @(negedge aclk); #1; k++; end
        check("aw_ready_seen", k < 50, 1);
        for (int b = 0; b <= len; b++) begin
            @(negedge aclk);
            axi.axi_awvalid = 1'b0;
            d = seed + 64'(b);
            axi.axi_wdata = DW'(d);
            axi.axi_wstrb = SB'(strb);
            axi.axi_wlast = (b == last_at);
            axi.axi_wvalid = 1'b1;
            #1;
            k = 0;
            while (!axi.axi_wready && k < 50) begin @(negedge aclk); #1; k++; end
            check("w_ready_seen", k < 50, 1);
            if (!oor)
                for (int j = 0; j < 8; j++)
                    if (strb[j]) model[(widx + b) % MEM][8*j +: 8] = d[8*j +: 8];
        end
        @(negedge aclk);
        axi.axi_wvalid = 1'b0;
        axi.axi_wlast = 1'b0;
        #1;
        k = 0;
        while (!axi.axi_bvalid && k < 50) begin @(negedge aclk); #1; k++; end
        check("b_valid_seen", k < 50, 1);
        check("b_id", axi.axi_bid, id);
        check("b_resp", axi.axi_bresp, oor ? 2'b10 : 2'b00);
        check("proto_err", proto_err, exp_proto);
        axi.axi_bready = 1'b1;
        @(negedge aclk);
        axi.axi_bready = 1'b0;
        #1;
        check("b_single", axi.axi_bvalid, 0);
    endtask

    task automatic do_read(input logic [3:0] id, input int widx, input int len, input bit rnd);
        int k, got, cyc;
        bit oor, seen, stalled;
        logic [63:0] pd;
        logic pl;
        logic [64:0] e;
        oor = range_oor(widx, len);
        for (int b = 0; b <= len; b++)
            exp_q.push_back({b == len, oor ? 64'd0 : model[(widx + b) % MEM]});
        axi.axi_arid = id;
        axi.axi_araddr = 32'(widx * SB);
        axi.axi_arlen = 8'(len);
        axi.axi_arvalid = 1'b1;
        #1;
        k = 0;
        while (!axi.axi_arready && k < 50) begin @(negedge aclk); #1; k++; end
        check("ar_ready_seen", k < 50, 1);
        got = 0; cyc = 0; seen = 0; stalled = 0; pd = '0; pl = 1'b0;
        while (got <= len && cyc < 4000) begin
            @(negedge aclk);
            axi.axi_arvalid = 1'b0;
            axi.axi_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            cyc++;
            if (axi.axi_rvalid) begin
                if (!seen) begin check("r_first_latency", cyc, 2); seen = 1; end
                if (stalled) begin
                    check("r_hold_data", axi.axi_rdata[63:0], pd);
                    check("r_hold_last", axi.axi_rlast, pl);
                end
                if (axi.axi_rready) begin
                    e = exp_q.pop_front();
                    check("r_data", axi.axi_rdata[63:0], e[63:0]);
                    check("r_upper_zero", |axi.axi_rdata[DW-1:64], 0);
                    check("r_last", axi.axi_rlast, e[64]);
                    check("r_id", axi.axi_rid, id);
                    check("r_resp", axi.axi_rresp, oor ? 2'b10 : 2'b00);
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pd = axi.axi_rdata[63:0];
                    pl = axi.axi_rlast;
                end
            end
        end
        check("r_beat_count", got, len + 1);
        check("r_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        axi.axi_rready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        axi.axi_awid = '0; axi.axi_awaddr = '0; axi.axi_awlen = '0; axi.axi_awvalid = 1'b0;
        axi.axi_wdata = '0; axi.axi_wstrb = '0; axi.axi_wlast = 1'b0; axi.axi_wvalid = 1'b0;
        axi.axi_bready = 1'b0;
        axi.axi_arid = '0; axi.axi_araddr = '0; axi.axi_arlen = '0; axi.axi_arvalid = 1'b0;
        axi.axi_rready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #1;
        check("rst_awready", axi.axi_awready, 0);
        check("rst_arready", axi.axi_arready, 0);
        check("rst_wready", axi.axi_wready, 0);
        check("rst_bvalid", axi.axi_bvalid, 0);
        check("rst_rvalid", axi.axi_rvalid, 0);
        check("rst_rlast", axi.axi_rlast, 0);
        check("rst_rdata", axi.axi_rdata[63:0], 0);
        check("rst_proto_err", proto_err, 0);
        @(negedge aclk);
        rst = 1'b0;
        #1;
        check("idle_awready", axi.axi_awready, 1);
        check("idle_arready", axi.axi_arready, 1);

        // Full 256-beat write then read-back of the same range.
        do_write(4'h9, 0, 255, 255, 64'd0, 8'hFF, 1'b0);
        do_read(4'h6, 0, 255, 1'b0);

        // Simultaneous AW/AR: write goes first, read returns the fresh data.
        axi.axi_arid = 4'h5;
        axi.axi_araddr = 32'(100 * SB);
        axi.axi_arlen = 8'd3;
        axi.axi_arvalid = 1'b1;
        do_write(4'h3, 100, 3, 3, 64'hA5A5_0000_0000_1000, 8'hFF, 1'b0);
        do_read(4'h5, 100, 3, 1'b0);

        // Back-pressured read.
        do_read(4'hC, 0, 31, 1'b1);

        // Partial byte strobes merge into an existing word.
        do_write(4'h1, 500, 0, 0, 64'h1122_3344_5566_7788, 8'hFF, 1'b0);
        do_write(4'h2, 500, 0, 0, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1'b0);
        do_read(4'h2, 500, 0, 1'b0);

        // Early wlast: all eight beats still taken, sticky error until reset.
        do_write(4'h7, 600, 7, 3, 64'h7000, 8'hFF, 1'b1);
        do_read(4'h7, 600, 7, 1'b0);
        check("proto_sticky", proto_err, 1);
        rst = 1'b1;
        @(negedge aclk);
        #1;
        check("proto_cleared", proto_err, 0);
        rst = 1'b0;
        #1;

        // Burst crossing the top of the store: wraps, or SLVERR with range checking.
        do_write(4'hE, MEM - 4, 7, 7, 64'hE000, 8'hFF, 1'b0);
        do_read(4'hE, MEM - 4, 7, 1'b0);
        do_read(4'hD, 0, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
